// File: rtl/lcd_text_writer.sv
// rtl/lcd_text_writer.sv - character stream to text-RAM writer with cursor, scrolling and clears
module lcd_text_writer #(
  parameter int COLUMNS = 100,
  parameter int ROWS    = 30
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        char_valid,
  input  logic [7:0]  char_data,
  output logic        char_ready,
  output logic        wr_en,
  output logic [11:0] wr_address,
  output logic [7:0]  wr_data,
  output logic [6:0]  cursor_column,
  output logic [5:0]  cursor_row,
  output logic [5:0]  scroll_row
);

  typedef enum logic [1:0] {
    CLEAR_ALL  = 2'd0,
    IDLE       = 2'd1,
    CLEAR_LINE = 2'd2
  } state_t;

  localparam logic [11:0] CELLS_LAST = 12'(COLUMNS * ROWS - 1);
  localparam logic [11:0] COLS_LAST  = 12'(COLUMNS - 1);
  localparam logic [11:0] COLS12     = 12'(COLUMNS);
  localparam logic [6:0]  COL_MAX    = 7'(COLUMNS - 1);
  localparam logic [5:0]  ROW_MAX    = 6'(ROWS - 1);
  localparam logic [6:0]  ROWS7      = 7'(ROWS);

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_TILDE = 8'h7E;

  state_t      state_q, state_d;
  logic [6:0]  col_q, col_d;
  logic [5:0]  row_q, row_d;
  logic [5:0]  scroll_q, scroll_d;
  logic [11:0] cnt_q, cnt_d;
  logic        wr_en_q, wr_en_d;
  logic [11:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;

  logic [6:0]  row_sum;
  logic [5:0]  phys_row;
  logic [11:0] row_base;
  logic        do_newline;

  // Map the logical cursor row onto a physical RAM row; the sum is below 2*ROWS so one subtract suffices
  always_comb begin
    row_sum = {1'b0, row_q} + {1'b0, scroll_q};
    if (row_sum >= ROWS7) begin
      row_sum = row_sum - ROWS7;
    end
    phys_row = row_sum[5:0];
    row_base = 12'(phys_row) * COLS12;
  end

  // Next-state logic: clear sweeps, character handling, cursor and scroll updates
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    scroll_d   = scroll_q;
    cnt_d      = cnt_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    do_newline = 1'b0;

    case (state_q)
      CLEAR_ALL: begin
        wr_en_d   = 1'b1;
        wr_addr_d = cnt_q;
        wr_data_d = CH_SPACE;
        if (cnt_q == CELLS_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end

      CLEAR_LINE: begin
        // Cursor sits on the bottom row here, so phys_row is the freshly exposed line
        wr_en_d   = 1'b1;
        wr_addr_d = row_base + cnt_q;
        wr_data_d = CH_SPACE;
        if (cnt_q == COLS_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end

      IDLE: begin
        if (char_valid) begin
          if (char_data >= CH_SPACE && char_data <= CH_TILDE) begin
            wr_en_d   = 1'b1;
            wr_addr_d = row_base + {5'd0, col_q};
            wr_data_d = char_data;
            if (col_q == COL_MAX) begin
              do_newline = 1'b1;
            end else begin
              col_d = col_q + 7'd1;
            end
          end else begin
            case (char_data)
              CH_LF: do_newline = 1'b1;
              CH_CR: col_d = '0;
              CH_BS: begin
                if (col_q != 7'd0) begin
                  col_d = col_q - 7'd1;
                end
              end
              CH_FF: begin
                col_d    = '0;
                row_d    = '0;
                scroll_d = '0;
                cnt_d    = '0;
                state_d  = CLEAR_ALL;
              end
              default: ;
            endcase
          end

          if (do_newline) begin
            col_d = '0;
            if (row_q < ROW_MAX) begin
              row_d = row_q + 6'd1;
            end else begin
              scroll_d = (scroll_q == ROW_MAX) ? 6'd0 : scroll_q + 6'd1;
              cnt_d    = '0;
              state_d  = CLEAR_LINE;
            end
          end
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = CLEAR_ALL;
      end
    endcase
  end

  // State and output registers; reset forces a full-screen clear from address 0
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= CLEAR_ALL;
      col_q     <= '0;
      row_q     <= '0;
      scroll_q  <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      scroll_q  <= scroll_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign char_ready    = (state_q == IDLE);
  assign wr_en         = wr_en_q;
  assign wr_address    = wr_addr_q;
  assign wr_data       = wr_data_q;
  assign cursor_column = col_q;
  assign cursor_row    = row_q;
  assign scroll_row    = scroll_q;

endmodule
